pixel_write_scheduler: RTL and testbench
========================================

Name: pixel_write_scheduler

Overview:
Owns the single write port of the pixel RAM and sequences every pixel write into it. It serves two requesters. The first is a CPU store path that delivers 32-bit words of four packed 8-bit pixels. The second is a built-in fill engine that writes a constant value over a linear address range (screen clear, rectangle rows). It sits between the processor/loader and the pixel RAM write port; the VGA read side is untouched.

Parameters:
ADDR_W, 18, pixel RAM address width; all address arithmetic is modulo 2^ADDR_W.
PIX_W, 8, pixel width in bits; CPU word width is 4*PIX_W.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_req  in  1  CPU write request; held with stable addr/data until cpu_ack
cpu_addr  in  ADDR_W  pixel address of byte 0 of the word
cpu_data  in  4*PIX_W  packed pixels; byte0 = bits [PIX_W-1:0]
cpu_ack  out  1  one-cycle pulse: word accepted (coincides with byte0 write)
fill_start  in  1  start pulse; accepted only while fill_busy=0
fill_base  in  ADDR_W  first fill address
fill_count  in  ADDR_W  number of pixels to fill
fill_value  in  PIX_W  fill pixel value
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse with the final fill write
ram_wren  out  1  write enable to pixel RAM
ram_wraddress  out  ADDR_W  write address
ram_data  out  PIX_W  write data

Behaviour:
- Reset: cpu_ack, fill_busy, fill_done and ram_wren = 0; ram_wraddress and ram_data = 0; fill engine idle; last_grant = FILL, so the CPU wins the first tie. Reset mid-operation aborts immediately. No further writes occur, and writes already issued remain in RAM.
- All outputs are registered. At most one RAM write per cycle.
- FSM states:
  - IDLE: no write this cycle.
  - CPU_B0..CPU_B3: ram_wraddress = latched addr + i (mod 2^ADDR_W), ram_data = byte i.
  - FILL_WR: one fill pixel per cycle.
- Decision point: every clock edge at which the FSM is not in CPU_B0..CPU_B2. Arbitration at a decision point:
  - Only cpu_req pending: grant CPU.
  - Only fill pending (fill_busy and remaining > 0): grant FILL.
  - Both pending: grant the requester not equal to last_grant (round robin). A CPU grant covers 4 writes; a FILL grant covers 1 write.
  - Neither pending: go to IDLE.
- CPU grant at edge E:
  - cpu_addr and cpu_data are latched at E.
  - Cycle after E: cpu_ack = 1 and byte0 is written (CPU_B0).
  - Bytes 1..3 follow in the next 3 cycles.
  - The next grant can occur at the edge ending CPU_B3, so there is no bubble.
  - cpu_req is not sampled during CPU_B0..CPU_B2.
- Fill start:
  - fill_start with fill_busy=0 latches base, count and value; fill_busy = 1 from the next cycle.
  - fill_start while busy (including the final-write cycle) is ignored.
- Fill with fill_count = 0: fill_done pulses the cycle after start, fill_busy stays 0, and no writes occur.
- Fill writes proceed base, base+1, ..., base+count-1, wrapping modulo 2^ADDR_W.
- Fill termination: fill_done = 1 and fill_busy = 1 in the cycle of the final write; fill_busy = 0 from the next cycle.
- A fill alone sustains 1 pixel/cycle. With a continuous CPU stream, the pattern is 4 CPU writes, then 1 fill write, repeated. Neither side starves.
- fill_start and cpu_req in the same cycle:
  - The start is latched at that edge.
  - The fill counts as pending from the next decision point, so the CPU is granted at that edge.
- Address wrap for CPU words: cpu_addr = 2^ADDR_W-2 writes bytes to addresses 3FFFE, 3FFFF, 00000, 00001 (ADDR_W=18).

Test Plan:
1. Single CPU word: cpu_addr=0x00100, cpu_data=0xDDCCBBAA → cpu_ack pulses once. Four consecutive writes: (0x00100,AA), (0x00101,BB), (0x00102,CC), (0x00103,DD). Then ram_wren=0.
2. Fill alone: base=0x3FFFE, count=4, value=0x55 → writes at 3FFFE, 3FFFF, 00000, 00001 on 4 consecutive cycles. fill_done is high with the 00001 write; fill_busy falls next cycle.
3. Contention: fill count=3 running while cpu_req is held continuously with new words → ram_wren pattern is CPU×4, F, CPU×4, F, CPU×4, F. fill_done is high with the 3rd F write, and the CPU stream continues with no idle cycles.
4. Zero-length and busy start: fill_count=0 → fill_done one cycle after start and no ram_wren. A second fill_start during an active fill → ignored: the original range is completed and no extra writes occur.
5. Reset mid-sequence: assert reset during CPU_B1 → at the next edge all outputs = 0 and no more writes. After release, a fresh CPU word with a pending fill → CPU granted first.
6. Simultaneous events: fill_start and cpu_req in the same cycle → CPU byte0 is written first, and the first fill write occurs immediately after CPU_B3.

Source files
------------

// File: rtl/pixel_write_scheduler.sv
// Pixel RAM write-port scheduler: CPU 4-pixel word stores and a
// constant-value linear fill engine, round-robin arbitrated.
module pixel_write_scheduler #(
    parameter int ADDR_W = 18,
    parameter int PIX_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [4*PIX_W-1:0]   cpu_data,
    output logic                 cpu_ack,
    input  logic                 fill_start,
    input  logic [ADDR_W-1:0]    fill_base,
    input  logic [ADDR_W-1:0]    fill_count,
    input  logic [PIX_W-1:0]     fill_value,
    output logic                 fill_busy,
    output logic                 fill_done,
    output logic                 ram_wren,
    output logic [ADDR_W-1:0]    ram_wraddress,
    output logic [PIX_W-1:0]     ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_B0,
        CPU_B1,
        CPU_B2,
        CPU_B3,
        FILL_WR
    } state_t;

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   lat_addr;
    logic [4*PIX_W-1:0]  lat_data;
    logic                last_fill;
    logic [ADDR_W-1:0]   fill_ptr;
    logic [ADDR_W-1:0]   fill_rem;
    logic [PIX_W-1:0]    fill_val;

    logic                cpu_pend;
    logic                fill_pend;
    logic                fill_accept;
    logic                grant_cpu;
    logic                grant_fill;
    logic                wren_n;
    logic                ack_n;
    logic                done_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [PIX_W-1:0]    data_n;

    assign cpu_pend    = cpu_req;
    assign fill_pend   = fill_busy && (fill_rem != '0);
    assign fill_accept = fill_start && !fill_busy;

    always_comb begin
        state_n    = IDLE;
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        wren_n     = 1'b0;
        ack_n      = 1'b0;
        done_n     = 1'b0;
        addr_n     = ram_wraddress;
        data_n     = ram_data;
        unique case (state)
            CPU_B0: begin
                state_n = CPU_B1;
                wren_n  = 1'b1;
                addr_n  = lat_addr + ADDR_W'(1);
                data_n  = lat_data[PIX_W +: PIX_W];
            end
            CPU_B1: begin
                state_n = CPU_B2;
                wren_n  = 1'b1;
                addr_n  = lat_addr + ADDR_W'(2);
                data_n  = lat_data[2*PIX_W +: PIX_W];
            end
            CPU_B2: begin
                state_n = CPU_B3;
                wren_n  = 1'b1;
                addr_n  = lat_addr + ADDR_W'(3);
                data_n  = lat_data[3*PIX_W +: PIX_W];
            end
            default: begin
                // Decision point: round robin only matters on a tie
                if (cpu_pend && (!fill_pend || last_fill)) begin
                    grant_cpu = 1'b1;
                end else if (fill_pend) begin
                    grant_fill = 1'b1;
                end
                if (grant_cpu) begin
                    state_n = CPU_B0;
                    wren_n  = 1'b1;
                    ack_n   = 1'b1;
                    addr_n  = cpu_addr;
                    data_n  = cpu_data[PIX_W-1:0];
                end else if (grant_fill) begin
                    state_n = FILL_WR;
                    wren_n  = 1'b1;
                    addr_n  = fill_ptr;
                    data_n  = fill_val;
                    done_n  = (fill_rem == ADDR_W'(1));
                end
            end
        endcase
        if (fill_accept && (fill_count == '0)) begin
            done_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            lat_addr      <= '0;
            lat_data      <= '0;
            last_fill     <= 1'b1;
            cpu_ack       <= 1'b0;
            fill_done     <= 1'b0;
            ram_wren      <= 1'b0;
            ram_wraddress <= '0;
            ram_data      <= '0;
        end else begin
            state         <= state_n;
            cpu_ack       <= ack_n;
            fill_done     <= done_n;
            ram_wren      <= wren_n;
            ram_wraddress <= addr_n;
            ram_data      <= data_n;
            if (grant_cpu) begin
                lat_addr  <= cpu_addr;
                lat_data  <= cpu_data;
                last_fill <= 1'b0;
            end else if (grant_fill) begin
                last_fill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_busy <= 1'b0;
            fill_ptr  <= '0;
            fill_rem  <= '0;
            fill_val  <= '0;
        end else begin
            if (fill_accept) begin
                if (fill_count != '0) begin
                    fill_busy <= 1'b1;
                    fill_ptr  <= fill_base;
                    fill_rem  <= fill_count;
                    fill_val  <= fill_value;
                end
            end else if (grant_fill) begin
                fill_ptr <= fill_ptr + ADDR_W'(1);
                fill_rem <= fill_rem - ADDR_W'(1);
            end else if (fill_busy && fill_done) begin
                // Busy stays up through the final-write cycle
                fill_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Scoreboard bench for pixel_write_scheduler: expected writes are
// queued at stimulus time and popped on every observed RAM write.
module tb_pixel_write_scheduler;

    localparam int AW = 18;
    localparam int PW = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [PW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [4*PW-1:0] data;
    } word_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            cpu_req;
    logic [AW-1:0]   cpu_addr;
    logic [4*PW-1:0] cpu_data;
    logic            cpu_ack;
    logic            fill_start;
    logic [AW-1:0]   fill_base;
    logic [AW-1:0]   fill_count;
    logic [PW-1:0]   fill_value;
    logic            fill_busy;
    logic            fill_done;
    logic            ram_wren;
    logic [AW-1:0]   ram_wraddress;
    logic [PW-1:0]   ram_data;

    wr_t   exp_q[$];
    word_t word_q[$];
    int    checks = 0;
    int    fails  = 0;

    pixel_write_scheduler #(.ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_data(cpu_data),
        .cpu_ack(cpu_ack),
        .fill_start(fill_start),
        .fill_base(fill_base),
        .fill_count(fill_count),
        .fill_value(fill_value),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .ram_wren(ram_wren),
        .ram_wraddress(ram_wraddress),
        .ram_data(ram_data)
    );

    always #5 clk = ~clk;

    task automatic push_word(input logic [AW-1:0] a,
                             input logic [4*PW-1:0] d);
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = a + AW'(i);
            e.data = d[i*PW +: PW];
            exp_q.push_back(e);
        end
    endtask

    task automatic push_fill(input logic [AW-1:0] a,
                             input logic [PW-1:0] v);
        wr_t e;
        e.addr = a;
        e.data = v;
        exp_q.push_back(e);
    endtask

    // One clock; scoreboard any write, then advance the CPU driver
    task automatic step();
        wr_t e;
        word_t w;
        @(posedge clk);
        #1;
        if (ram_wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%h data=%h",
                         ram_wraddress, ram_data);
            end else begin
                e = exp_q.pop_front();
                if ({ram_wraddress, ram_data} !== {e.addr, e.data}) begin
                    fails++;
                    $display("FAIL write got=%h/%h exp=%h/%h",
                             ram_wraddress, ram_data, e.addr, e.data);
                end
            end
        end
        if (cpu_ack === 1'b1) begin
            if (word_q.size() > 0) begin
                w = word_q.pop_front();
                cpu_addr = w.addr;
                cpu_data = w.data;
            end else begin
                cpu_req = 1'b0;
            end
        end
        fill_start = 1'b0;
    endtask

    task automatic start_fill(input logic [AW-1:0] b,
                              input logic [AW-1:0] c,
                              input logic [PW-1:0] v);
        fill_start = 1'b1;
        fill_base  = b;
        fill_count = c;
        fill_value = v;
    endtask

    task automatic expect_bit(input string name, input logic got,
                              input logic exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s pending_writes=%0d exp=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({cpu_ack, fill_busy, fill_done, ram_wren} !== 4'b0 ||
            ram_wraddress !== '0 || ram_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%b%b%b%b %h %h exp=0",
                     cpu_ack, fill_busy, fill_done, ram_wren,
                     ram_wraddress, ram_data);
        end
        reset = 1'b0;
        step();
        expect_bit("idle_after_reset", ram_wren, 1'b0);
    endtask

    task automatic test_cpu_word();
        int acks = 0;
        cpu_req  = 1'b1;
        cpu_addr = 18'h00100;
        cpu_data = 32'hDDCCBBAA;
        push_word(18'h00100, 32'hDDCCBBAA);
        for (int i = 1; i <= 7; i++) begin
            step();
            if (cpu_ack === 1'b1) acks++;
            if (i == 1) expect_bit("cpu_ack_b0", cpu_ack, 1'b1);
            if (i <= 4) expect_bit("cpu_wren", ram_wren, 1'b1);
            if (i == 5) expect_bit("cpu_wren_end", ram_wren, 1'b0);
        end
        checks++;
        if (acks != 1) begin
            fails++;
            $display("FAIL cpu_ack_count got=%0d exp=1", acks);
        end
        queue_empty("cpu_word");
    endtask

    task automatic test_fill_wrap();
        start_fill(18'h3FFFE, 18'd4, 8'h55);
        for (int i = 0; i < 4; i++)
            push_fill(18'h3FFFE + AW'(i), 8'h55);
        step();
        expect_bit("fill_busy_rise", fill_busy, 1'b1);
        expect_bit("fill_no_write_start", ram_wren, 1'b0);
        for (int i = 2; i <= 5; i++) begin
            step();
            expect_bit("fill_wren", ram_wren, 1'b1);
            expect_bit("fill_done_timing", fill_done, i == 5);
        end
        expect_bit("fill_busy_last", fill_busy, 1'b1);
        step();
        expect_bit("fill_busy_fall", fill_busy, 1'b0);
        expect_bit("fill_done_fall", fill_done, 1'b0);
        queue_empty("fill_wrap");
    endtask

    task automatic test_contention();
        word_t w;
        cpu_req  = 1'b1;
        cpu_addr = 18'h01000;
        cpu_data = 32'h03020100;
        w.addr = 18'h01004; w.data = 32'h13121110; word_q.push_back(w);
        w.addr = 18'h01008; w.data = 32'h23222120; word_q.push_back(w);
        start_fill(18'h02000, 18'd3, 8'h77);
        push_word(18'h01000, 32'h03020100);
        push_fill(18'h02000, 8'h77);
        push_word(18'h01004, 32'h13121110);
        push_fill(18'h02001, 8'h77);
        push_word(18'h01008, 32'h23222120);
        push_fill(18'h02002, 8'h77);
        for (int i = 1; i <= 15; i++) begin
            step();
            expect_bit("cont_no_bubble", ram_wren, 1'b1);
            expect_bit("cont_done", fill_done, i == 15);
        end
        step();
        expect_bit("cont_idle_end", ram_wren, 1'b0);
        expect_bit("cont_busy_end", fill_busy, 1'b0);
        queue_empty("contention");
    endtask

    task automatic test_zero_and_busy();
        int dones = 0;
        start_fill(18'h00050, 18'd0, 8'hEE);
        step();
        expect_bit("zero_done", fill_done, 1'b1);
        expect_bit("zero_busy", fill_busy, 1'b0);
        step();
        expect_bit("zero_done_pulse", fill_done, 1'b0);
        expect_bit("zero_no_write", ram_wren, 1'b0);
        start_fill(18'h00200, 18'd5, 8'h11);
        for (int i = 0; i < 5; i++)
            push_fill(18'h00200 + AW'(i), 8'h11);
        step();
        start_fill(18'h00300, 18'd2, 8'h99);
        for (int i = 0; i < 10; i++) begin
            step();
            if (fill_done === 1'b1) begin
                dones++;
                start_fill(18'h00400, 18'd2, 8'h88);
            end
        end
        checks++;
        if (dones != 1) begin
            fails++;
            $display("FAIL busy_start_done_count got=%0d exp=1", dones);
        end
        expect_bit("busy_start_idle", fill_busy, 1'b0);
        queue_empty("zero_and_busy");
    endtask

    task automatic test_reset_mid();
        cpu_req  = 1'b1;
        cpu_addr = 18'h00400;
        cpu_data = 32'h44332211;
        push_fill(18'h00400, 8'h11);
        push_fill(18'h00401, 8'h22);
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({cpu_ack, fill_busy, fill_done, ram_wren} !== 4'b0 ||
            ram_wraddress !== '0 || ram_data !== '0) begin
            fails++;
            $display("FAIL reset_mid got=%b%b%b%b %h %h exp=0",
                     cpu_ack, fill_busy, fill_done, ram_wren,
                     ram_wraddress, ram_data);
        end
        reset = 1'b0;
        step();
        step();
        queue_empty("reset_mid_writes");
        start_fill(18'h00500, 18'd2, 8'h66);
        step();
        cpu_req  = 1'b1;
        cpu_addr = 18'h00600;
        cpu_data = 32'hA3A2A1A0;
        push_word(18'h00600, 32'hA3A2A1A0);
        push_fill(18'h00500, 8'h66);
        push_fill(18'h00501, 8'h66);
        step();
        expect_bit("post_reset_cpu_first", cpu_ack, 1'b1);
        for (int i = 0; i < 7; i++) step();
        queue_empty("post_reset");
    endtask

    task automatic test_simultaneous();
        cpu_req  = 1'b1;
        cpu_addr = 18'h3FFFE;
        cpu_data = 32'hB3B2B1B0;
        start_fill(18'h00700, 18'd2, 8'h5A);
        push_word(18'h3FFFE, 32'hB3B2B1B0);
        push_fill(18'h00700, 8'h5A);
        push_fill(18'h00701, 8'h5A);
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 1) expect_bit("simul_ack", cpu_ack, 1'b1);
            expect_bit("simul_wren", ram_wren, 1'b1);
        end
        expect_bit("simul_done", fill_done, 1'b1);
        step();
        expect_bit("simul_idle", ram_wren, 1'b0);
        queue_empty("simultaneous");
    endtask

    initial begin
        reset      = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = '0;
        cpu_data   = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_count = '0;
        fill_value = '0;
        test_reset();
        test_cpu_word();
        test_fill_wrap();
        test_contention();
        test_zero_and_busy();
        test_reset_mid();
        test_simultaneous();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
